// File: rtl/word_pkt_buf_pkg.sv
// Shared definitions for the word packet buffer.
//   state_t   : framing FSM states (ACCEPT, DROP)
//   WORD_W    : data word width coming from the 10b-to-32b packer
//   lvl_width : width of an occupancy count for a FIFO of a given depth
package word_pkt_buf_pkg;

  typedef enum logic {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } state_t;

  localparam int WORD_W = 32;

  // Occupancy ranges 0..depth inclusive, so one bit more than the address.
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointers only)
//   push      : write push_dat this cycle (caller guarantees not full)
//   push_dat  : WIDTH-bit write data
//   pop       : advance the head this cycle (caller guarantees not empty)
//   head_dat  : current head entry, valid whenever empty is low
//   empty     : no entries stored
//   full      : DEPTH entries stored
//   level     : number of entries stored, 0..DEPTH
module fifo_sync
  import word_pkt_buf_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_dat,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head_dat,
  output logic                          empty,
  output logic                          full,
  output logic [lvl_width(DEPTH)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; entries are only ever read behind valid pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign head_dat = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  // Same slot but different lap bit means the writer is a full lap ahead.
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level    = wr_ptr - rd_ptr;

endmodule

// File: rtl/word_pkt_buf.sv
// Packet framing buffer behind the 10b-to-32b packer.
// Absorbs an unthrottled word stream, groups every PKT_WORDS words into a
// packet (last flag on the final word) and admits or drops each packet as a
// whole, so the consumer never sees a partial packet.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_vld/i_dat: incoming word stream, no backpressure
//   o_vld/o_dat/o_last/o_rdy : FWFT valid/ready output with packet framing
//   o_ovfl     : sticky, at least one packet dropped since reset
//   o_drop_cnt : saturating dropped-packet count
//   o_lvl      : FIFO occupancy
module word_pkt_buf
  import word_pkt_buf_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int PKT_WORDS = 8,
  parameter int DCNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_vld,
  input  logic [WORD_W-1:0]            i_dat,
  output logic                         o_vld,
  output logic [WORD_W-1:0]            o_dat,
  output logic                         o_last,
  input  logic                         o_rdy,
  output logic                         o_ovfl,
  output logic [DCNT_W-1:0]            o_drop_cnt,
  output logic [lvl_width(DEPTH)-1:0]  o_lvl
);

  localparam int LVL_W  = lvl_width(DEPTH);
  localparam int BEAT_W = $clog2(PKT_WORDS);

  localparam logic [LVL_W-1:0]  DEPTH_L   = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  PKT_L     = LVL_W'(PKT_WORDS);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_WORDS - 1);

  state_t            state;
  logic [BEAT_W-1:0] beat;
  logic              room;
  logic              push;
  logic              pop;
  logic              empty;
  logic              full;
  logic [WORD_W:0]   head;

  // Admission looks only at registered occupancy; a pop in the same cycle
  // is deliberately not credited, keeping the check conservative.
  assign room = (DEPTH_L - o_lvl) >= PKT_L;

  always_comb begin
    push = 1'b0;
    if (!rst && i_vld) begin
      if (beat == '0) push = room;
      else            push = (state == ACCEPT);
    end
  end

  assign pop = o_vld & o_rdy;

  fifo_sync #(
    .WIDTH (WORD_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({beat == BEAT_LAST, i_dat}),
    .pop      (pop),
    .head_dat (head),
    .empty    (empty),
    .full     (full),
    .level    (o_lvl)
  );

  assign o_vld  = ~empty;
  assign o_dat  = head[WORD_W-1:0];
  assign o_last = head[WORD_W];

  // Framing FSM: beat counts every input word regardless of state; the
  // accept/drop decision is taken only on the first word of a packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACCEPT;
      beat       <= '0;
      o_ovfl     <= 1'b0;
      o_drop_cnt <= '0;
    end else if (i_vld) begin
      beat <= (beat == BEAT_LAST) ? '0 : beat + 1'b1;
      if (beat == '0) begin
        if (room) begin
          state <= ACCEPT;
        end else begin
          state  <= DROP;
          o_ovfl <= 1'b1;
          if (o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + 1'b1;
        end
      end
    end
  end

  // Whole-packet reservation means an admitted word always finds space.
  a_no_push_when_full : assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule
